// File: rtl/stream_to_bram.sv
// stream_to_bram
// Capture engine: records accepted 32-bit AXI-stream beats into a BRAM port
// as consecutive 32-bit words. A capture is armed by a pulse and starts
// either immediately or on the next orbit-sync fast command. It runs for a
// programmable number of words, then holds a done status.
//
// Optional feature macro: STREAM_TO_BRAM_TLAST_EN
//   When defined, adds data_stream_TLAST. An accepted TLAST beat in CAPTURE
//   is written and then ends the capture early.
//
// Ports
//   clk, aresetn         IP clock, async active-low reset
//   arm, abort           single-cycle control pulses (abort wins)
//   sync_mode            0 = start at arm, 1 = start on fc_orbitSync
//   capture_len          words to capture (0 or > MEM_DEPTH = MEM_DEPTH)
//   fc_orbitSync         orbit-sync fast command
//   data_stream_*        32-bit AXI stream sink (always ready)
//   bram_*               BRAM write port (byte address, zero-latency write)
//   busy, capture_done   status
//   words_captured       beats written in the current or last capture
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | no capture; stream beats discarded
// ARMED   | waiting for fc_orbitSync
// CAPTURE | writing accepted beats to consecutive words
// DONE    | length (or TLAST) reached; capture_done held
module stream_to_bram #(
   parameter  int MEM_DEPTH = 2048,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic          aresetn,
   input  logic          arm,
   input  logic          abort,
   input  logic          sync_mode,
   input  logic [15:0]   capture_len,
   input  logic          fc_orbitSync,
   input  logic [31:0]   data_stream_TDATA,
   input  logic          data_stream_TVALID,
`ifdef STREAM_TO_BRAM_TLAST_EN
   input  logic          data_stream_TLAST,
`endif
   output logic          data_stream_TREADY,
   output logic          bram_CLK,
   output logic          bram_RST,
   output logic          bram_EN,
   output logic [3:0]    bram_WE,
   output logic [31:0]   bram_ADDR,
   output logic [31:0]   bram_DIN,
   output logic          busy,
   output logic          capture_done,
   output logic [AW:0]   words_captured
);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   localparam logic [16:0] DEPTH_17 = 17'(MEM_DEPTH);
   localparam logic [AW:0] DEPTH_W  = (AW+1)'(MEM_DEPTH);

   state_t        state;
   logic [AW:0]   len;
   logic [AW-1:0] word_addr;

   logic [16:0]   len_req;
   logic [AW:0]   len_arm;
   logic          capturing;
   logic          beat;
   logic          wr;
   logic          tlast_hit;
   logic          last_beat;

   assign len_req = {1'b0, capture_len};
   assign len_arm = (len_req == 17'd0 || len_req > DEPTH_17) ? DEPTH_W : (AW+1)'(len_req);

   // ARMED + sync behaves as CAPTURE in that same cycle so the sync beat is word 0.
   assign capturing = (state == CAPTURE) || (state == ARMED && fc_orbitSync);
   assign beat      = data_stream_TVALID && data_stream_TREADY;
   assign wr        = aresetn && capturing && beat && !abort;

`ifdef STREAM_TO_BRAM_TLAST_EN
   assign tlast_hit = data_stream_TLAST;
`else
   assign tlast_hit = 1'b0;
`endif

   assign last_beat = (words_captured + (AW+1)'(1) == len) || tlast_hit;

   assign data_stream_TREADY = aresetn;
   assign bram_CLK  = clk;
   assign bram_RST  = !aresetn;
   assign bram_EN   = 1'b1;
   assign bram_WE   = wr ? 4'hF : 4'h0;
   assign bram_DIN  = data_stream_TDATA;
   assign bram_ADDR = {{(30-AW){1'b0}}, word_addr, 2'b00};

   assign busy         = (state == ARMED) || (state == CAPTURE);
   assign capture_done = (state == DONE);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state          <= IDLE;
         len            <= '0;
         word_addr      <= '0;
         words_captured <= '0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (arm) begin
                  len            <= len_arm;
                  word_addr      <= '0;
                  words_captured <= '0;
                  state          <= sync_mode ? ARMED : CAPTURE;
               end
            end
            ARMED, CAPTURE: begin
               if (wr) begin
                  word_addr <= word_addr + AW'(1);
                  if (words_captured != DEPTH_W)
                     words_captured <= words_captured + (AW+1)'(1);
                  state <= last_beat ? DONE : CAPTURE;
               end else if (capturing) begin
                  state <= CAPTURE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_to_bram.sv
module tb_stream_to_bram;

   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          arm = 1'b0, abort = 1'b0, sync_mode = 1'b0, fc_orbitSync = 1'b0;
   logic [15:0]   capture_len = '0;
   logic [31:0]   tdata = '0;
   logic          tvalid = 1'b0, tlast = 1'b0;
   logic          tready, bram_CLK, bram_RST, bram_EN, busy, capture_done;
   logic [3:0]    bram_WE;
   logic [31:0]   bram_ADDR, bram_DIN;
   logic [AW:0]   words_captured;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   stream_to_bram #(.MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .aresetn(aresetn), .arm(arm), .abort(abort),
      .sync_mode(sync_mode), .capture_len(capture_len), .fc_orbitSync(fc_orbitSync),
      .data_stream_TDATA(tdata), .data_stream_TVALID(tvalid),
`ifdef STREAM_TO_BRAM_TLAST_EN
      .data_stream_TLAST(tlast),
`endif
      .data_stream_TREADY(tready), .bram_CLK(bram_CLK), .bram_RST(bram_RST),
      .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_ADDR(bram_ADDR), .bram_DIN(bram_DIN),
      .busy(busy), .capture_done(capture_done), .words_captured(words_captured)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a capture is "waiting" for sync or "running"; it ends
   // when the count reaches the target (or on TLAST when enabled).
   bit m_wait, m_run, m_done;
   int m_count, m_target;

   function automatic bit tlast_used();
`ifdef STREAM_TO_BRAM_TLAST_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_write();
      return tvalid && !abort && (m_run || (m_wait && fc_orbitSync));
   endfunction

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         m_wait = 0; m_run = 0; m_done = 0; m_count = 0; m_target = 0;
      end else begin
         bit w;
         w = m_write();
         if (abort) begin
            m_wait = 0; m_run = 0; m_done = 0;
         end else if (!m_wait && !m_run) begin
            if (arm) begin
               m_target = (capture_len == 0 || capture_len > DEPTH) ? DEPTH : int'(capture_len);
               m_count = 0; m_done = 0;
               m_run = !sync_mode; m_wait = sync_mode;
            end
         end else begin
            if (m_wait && fc_orbitSync) begin m_wait = 0; m_run = 1; end
            if (w) begin
               m_count++;
               if (m_count == m_target || (tlast_used() && tlast)) begin
                  m_run = 0; m_done = 1;
               end
            end
         end
      end
   end

   // Per-cycle compare plus a record of what the DUT wrote.
   logic [31:0] dut_mem [DEPTH];
   int nwr = 0;
   int first_addr = -1;

   always @(negedge clk) begin
      if (aresetn) begin
         bit w;
         w = m_write();
         chk("tready", 32'(tready), 32'd1);
         chk("we", 32'(bram_WE), w ? 32'hF : 32'h0);
         if (w) begin
            chk("addr", bram_ADDR, 32'(m_count * 4));
            chk("din", bram_DIN, tdata);
         end
         chk("busy", 32'(busy), 32'(m_wait || m_run));
         chk("done", 32'(capture_done), 32'(m_done));
         chk("words", 32'(words_captured), 32'(m_count));
         chk("en", 32'(bram_EN), 32'd1);
         chk("rst", 32'(bram_RST), 32'd0);
         if (bram_WE == 4'hF) begin
            if (nwr == 0) first_addr = int'(bram_ADDR);
            dut_mem[bram_ADDR[AW+1:2]] = bram_DIN;
            nwr++;
         end
      end
   end

   task automatic cyc(input bit a, input bit ab, input bit sy, input bit v,
                      input logic [31:0] d, input bit tl);
      arm = a; abort = ab; fc_orbitSync = sy; tvalid = v; tdata = d; tlast = tl;
      @(posedge clk); #1;
      arm = 0; abort = 0; fc_orbitSync = 0; tlast = 0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!capture_done && n < budget) begin cyc(0, 0, 0, 1, $urandom, 0); n++; end
      if (!capture_done) begin
         errors++;
         $display("FAIL wait_done: timeout after %0d cycles", budget);
      end
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_we", 32'(bram_WE), 32'h0);
      chk("rst_bram_rst", 32'(bram_RST), 32'd1);
      chk("rst_en", 32'(bram_EN), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(tready), 32'd0);
      @(posedge clk); #1; aresetn = 1;
      cyc(0, 0, 0, 0, 0, 0);

      // Immediate capture of 8 words
      nwr = 0; sync_mode = 0; capture_len = 8;
      cyc(1, 0, 0, 1, 32'hDEAD, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 32'hA0 + i, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'hBB, 0);
      chk("imm_nwr", 32'(nwr), 32'd8);
      for (int i = 0; i < 8; i++) chk("imm_data", dut_mem[i], 32'hA0 + i);
      chk("imm_done", 32'(capture_done), 32'd1);
      chk("imm_words", 32'(words_captured), 32'd8);

      // Orbit-sync start, length 4
      nwr = 0; sync_mode = 1; capture_len = 4;
      cyc(1, 0, 0, 1, 32'h11, 0);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, $urandom, 0);
      chk("orb_nowr", 32'(nwr), 32'd0);
      cyc(0, 0, 1, 1, 32'h55, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, $urandom, 0);
      chk("orb_word0", dut_mem[0], 32'h55);
      chk("orb_nwr", 32'(nwr), 32'd4);
      chk("orb_done", 32'(capture_done), 32'd1);

      // Length clamp (0 and oversize) with gappy valid
      for (int k = 0; k < 2; k++) begin
         nwr = 0; first_addr = -1; sync_mode = 0; capture_len = (k == 0) ? 16'd0 : 16'd100;
         cyc(1, 0, 0, 0, 0, 0);
         for (int i = 0; i < 40; i++) cyc(0, 0, 0, i % 2 == 0, $urandom, 0);
         chk("clamp_nwr", 32'(nwr), 32'd16);
         chk("clamp_first", 32'(first_addr), 32'd0);
         chk("clamp_words", 32'(words_captured), 32'd16);
         chk("clamp_done", 32'(capture_done), 32'd1);
      end

      // Abort after 3 words, then arm+abort in DONE, then restart at 0
      sync_mode = 0; capture_len = 10;
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, $urandom, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("abort_words", 32'(words_captured), 32'd3);
      chk("abort_busy", 32'(busy), 32'd0);
      capture_len = 2;
      cyc(1, 0, 0, 0, 0, 0);
      wait_done(10);
      cyc(1, 1, 0, 0, 0, 0);
      chk("armabort_done", 32'(capture_done), 32'd0);
      chk("armabort_busy", 32'(busy), 32'd0);
      nwr = 0; first_addr = -1; capture_len = 3;
      cyc(1, 0, 0, 0, 0, 0);
      wait_done(10);
      chk("rearm_first", 32'(first_addr), 32'd0);
      chk("rearm_nwr", 32'(nwr), 32'd3);

`ifdef STREAM_TO_BRAM_TLAST_EN
      nwr = 0; capture_len = 10;
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, $urandom, i == 5);
      chk("tlast_nwr", 32'(nwr), 32'd6);
      chk("tlast_words", 32'(words_captured), 32'd6);
      chk("tlast_done", 32'(capture_done), 32'd1);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         sync_mode = 1'($urandom_range(0, 1));
         capture_len = 16'($urandom_range(0, 20));
         cyc($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
             $urandom, $urandom_range(0, 9) == 0);
      end

      // Reset mid-capture
      abort = 1; @(posedge clk); #1; abort = 0;
      sync_mode = 0; capture_len = 12;
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, $urandom, 0);
      tvalid = 1;
      #2 aresetn = 0;
      #1;
      chk("midrst_we", 32'(bram_WE), 32'h0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_words", 32'(words_captured), 32'd0);
      chk("midrst_done", 32'(capture_done), 32'd0);
      chk("midrst_bram_rst", 32'(bram_RST), 32'd1);
      tvalid = 0;
      @(posedge clk); #1; aresetn = 1;
      cyc(0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_to_bram.md
Name: stream_to_bram

Overview:
- Capture engine: accepts a 32-bit AXI stream and writes accepted beats into a block RAM port as 32-bit words at consecutive word addresses.
- Mirror of the BRAM-to-stream playback path.
- Used to record link/ELink data into a BRAM for readback over AXI by a separate BRAM controller port.
- Capture is armed by a control input. It starts either immediately or on the next orbit-sync fast command, runs for a programmable number of words, then stops and holds a done status.

Parameters:
- MEM_DEPTH, 2048, BRAM depth in 32-bit words; power of two, 16..65536.
- AW, $clog2(MEM_DEPTH), word-address width; derived, not overridden.

Ports:
- clk  in  1  IP clock; also drives bram_CLK.
- aresetn  in  1  Reset, asynchronous assert, active low.
- arm  in  1  Single-cycle pulse; arms a capture.
- abort  in  1  Single-cycle pulse; cancels capture and returns to IDLE.
- sync_mode  in  1  0 = start immediately; 1 = start on fc_orbitSync.
- capture_len  in  16  Words to capture; 0 or >MEM_DEPTH means MEM_DEPTH. Sampled at arm.
- fc_orbitSync  in  1  Orbit-sync fast command, one cycle.
- data_stream_TDATA  in  32  Stream data.
- data_stream_TVALID  in  1  Stream valid.
- data_stream_TREADY  out  1  Stream ready.
- bram_CLK  out  1  = clk.
- bram_RST  out  1  = !aresetn.
- bram_EN  out  1  Constant 1.
- bram_WE  out  4  Byte write enables.
- bram_ADDR  out  32  Byte address = {zero-pad, word_addr, 2'b00}.
- bram_DIN  out  32  Write data.
- busy  out  1  High in ARMED or CAPTURE.
- capture_done  out  1  High in DONE.
- words_captured  out  AW+1  Beats written in the current or last capture.

Behaviour:
- Reset: all outputs low or zero except bram_RST=1, bram_CLK=clk, bram_EN=1. Registers clear asynchronously. bram_WE drops immediately on reset assertion, including mid-capture. State is IDLE.
- data_stream_TREADY = 1 in every state while out of reset. Beats accepted outside CAPTURE are discarded, so upstream never stalls.
- Write: in CAPTURE, when TVALID&&TREADY, bram_WE=4'hF, bram_DIN=TDATA, bram_ADDR=current word_addr, all combinational in the same cycle (zero latency). Otherwise bram_WE=0.
- FSM:
  - IDLE: on arm, latch len, clear word_addr and words_captured. Go to CAPTURE if sync_mode=0, else ARMED.
  - ARMED: on fc_orbitSync, enter capture in that same cycle; a beat accepted in that cycle is written as word 0. abort -> IDLE.
  - CAPTURE: each accepted beat increments word_addr and words_captured. On the beat that makes words_captured==len -> DONE. abort -> IDLE; words already written stay in RAM and words_captured holds.
  - DONE: holds capture_done. arm -> re-arm exactly as from IDLE.
- sync_mode=0: beats in the arm cycle itself are discarded; the first written beat is the cycle after arm.
- arm while in ARMED or CAPTURE is ignored. abort has priority over arm and over fc_orbitSync in the same cycle.
- fc_orbitSync outside ARMED is ignored.
- word_addr is AW bits. It cannot wrap, since len≤MEM_DEPTH ends capture at address MEM_DEPTH-1.
- words_captured saturates at MEM_DEPTH.
- sync_mode and capture_len may change at any time; only values at the arm cycle take effect.

Optional Feature:
- Macro: STREAM_TO_BRAM_TLAST_EN.
- Defined:
  - Adds input data_stream_TLAST (1 bit).
  - In CAPTURE, an accepted beat with TLAST=1 is written, then FSM goes to DONE even if words_captured<len.
  - TLAST outside CAPTURE is ignored.
- Undefined: port absent; capture ends only on length or abort.

Test Plan:
- Reset mid-capture: assert aresetn=0 after 5 writes -> bram_WE=0 in the same cycle; state IDLE; words_captured=0; busy=0.
- Immediate capture: sync_mode=0, capture_len=8, arm; TVALID=1 with TDATA=0xA0..0xA7 -> bram_ADDR 0x0,0x4..0x1C written with those values; capture_done=1 after the 8th beat; words_captured=8; later beats not written.
- Orbit start: sync_mode=1, len=4, arm, beats streaming, fc_orbitSync 10 cycles later with TDATA=0x55 -> 0x55 at address 0; 4 words total; no writes before sync.
- Length clamp and gaps: MEM_DEPTH=16, capture_len=0, TVALID toggling 1/0 -> exactly 16 writes at addresses 0x00..0x3C; done; words_captured=16.
- Abort and re-arm: abort after 3 words -> IDLE, words_captured=3. Same-cycle arm+abort in DONE -> IDLE. Subsequent arm restarts at address 0.
- With STREAM_TO_BRAM_TLAST_EN: len=10, TLAST on the 6th beat -> 6 writes; done; words_captured=6.
